// File: rtl/baud_gen_frac_pkg.sv
// Shared constants and divisor helpers for the fractional baud generator.
// Default divisor widths and the reset-divisor computation live here.
package baud_gen_frac_pkg;

  localparam int INT_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int MIN_DIV    = 2;

  // Divisor in fixed point (INT.FRAC), rounded to nearest LSB.
  function automatic longint div_q(
    input longint clk_hz,
    input longint baud,
    input longint ovs,
    input int     frac_w
  );
    longint den;
    den = baud * ovs;
    return ((clk_hz << frac_w) + (den / 2)) / den;
  endfunction

endpackage

// File: rtl/baud_gen_frac_divider.sv
// Fractional tick divider: down-counter plus phase accumulator.
// A carry out of the accumulator stretches the next period by one cycle.
module baud_gen_frac_divider #(
  parameter int               INT_W   = 16,
  parameter int               FRAC_W  = 4,
  parameter logic [INT_W-1:0] RST_CNT = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic              load_i,
  input  logic [INT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              tick_o
);

  logic [INT_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              w_tick;
  logic [FRAC_W:0]   w_sum;
  logic [INT_W-1:0]  w_reload;

  assign w_tick   = en_i && !sync_i && (r_cnt == '0);
  assign w_sum    = {1'b0, r_acc} + {1'b0, div_frac_i};
  assign w_reload = div_int_i - INT_W'(1);
  assign tick_o   = w_tick;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= RST_CNT;
      r_acc <= '0;
    end else if (!en_i || sync_i || (w_tick && load_i)) begin
      r_cnt <= w_reload;
      r_acc <= '0;
    end else if (w_tick) begin
      r_acc <= w_sum[FRAC_W-1:0];
      r_cnt <= w_reload + INT_W'(w_sum[FRAC_W]);
    end else begin
      r_cnt <= r_cnt - INT_W'(1);
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: rx oversample tick and phase-locked tx bit tick.
// Define BAUD_GEN_RX_SYNC_EN to let rx_sync_i restart the rx phase.
module baud_gen_frac
  import baud_gen_frac_pkg::*;
#(
  parameter int CLK_HZ    = 125000000,
  parameter int BAUD_RATE = 115200,
  parameter int OVS       = 16,
  parameter int INT_W     = INT_W_DEF,
  parameter int FRAC_W    = FRAC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              cfg_we_i,
  input  logic [INT_W-1:0]  cfg_int_i,
  input  logic [FRAC_W-1:0] cfg_frac_i,
  input  logic              rx_sync_i,
  output logic              cfg_pending_o,
  output logic [INT_W-1:0]  div_int_o,
  output logic [FRAC_W-1:0] div_frac_o,
  output logic              rxclk_en_o,
  output logic              txclk_en_o
);

  localparam longint DEF_Q =
    div_q(longint'(CLK_HZ), longint'(BAUD_RATE), longint'(OVS), FRAC_W);
  localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(DEF_Q >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_Q);
  localparam logic [INT_W-1:0]  MIN_INT  = INT_W'(MIN_DIV);
  localparam logic [INT_W-1:0]  DEF_EFF  =
    (DEF_INT < MIN_INT) ? MIN_INT : DEF_INT;
  localparam int                OVS_W    = $clog2(OVS);
  localparam logic [OVS_W-1:0]  OVS_LAST = OVS_W'(OVS - 1);

  logic [INT_W-1:0]  r_act_int;
  logic [FRAC_W-1:0] r_act_frac;
  logic [INT_W-1:0]  r_sh_int;
  logic [FRAC_W-1:0] r_sh_frac;
  logic              r_pending;
  logic [OVS_W-1:0]  r_ovs;
  logic              r_rx;
  logic              r_tx;

  logic              w_tick;
  logic              w_sync;
  logic              w_apply;
  logic [INT_W-1:0]  w_sel_int;
  logic [FRAC_W-1:0] w_sel_frac;
  logic [INT_W-1:0]  w_eff_int;

`ifdef BAUD_GEN_RX_SYNC_EN
  assign w_sync = en_i && rx_sync_i;
`else
  logic w_unused_sync;
  assign w_sync        = 1'b0;
  assign w_unused_sync = rx_sync_i;
`endif

  // While a write is pending, any reload already uses the shadow divisor.
  assign w_sel_int  = r_pending ? r_sh_int  : r_act_int;
  assign w_sel_frac = r_pending ? r_sh_frac : r_act_frac;
  assign w_eff_int  = (w_sel_int < MIN_INT) ? MIN_INT : w_sel_int;
  assign w_apply    = r_pending && (!en_i || w_sync || w_tick);

  baud_gen_frac_divider #(
    .INT_W   (INT_W),
    .FRAC_W  (FRAC_W),
    .RST_CNT (DEF_EFF - INT_W'(1))
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .sync_i     (w_sync),
    .load_i     (r_pending),
    .div_int_i  (w_eff_int),
    .div_frac_i (w_sel_frac),
    .tick_o     (w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_act_int  <= DEF_INT;
      r_act_frac <= DEF_FRAC;
      r_sh_int   <= DEF_INT;
      r_sh_frac  <= DEF_FRAC;
      r_pending  <= 1'b0;
      r_ovs      <= '0;
      r_rx       <= 1'b0;
      r_tx       <= 1'b0;
    end else begin
      r_rx <= w_tick;
      r_tx <= w_tick && (r_ovs == OVS_LAST);
      if (!en_i) begin
        r_ovs <= '0;
      end else if (w_tick) begin
        r_ovs <= (r_ovs == OVS_LAST) ? '0 : r_ovs + OVS_W'(1);
      end
      if (w_apply) begin
        r_act_int  <= r_sh_int;
        r_act_frac <= r_sh_frac;
      end
      // A write landing on an apply cycle stays pending for the next one.
      if (cfg_we_i) begin
        r_sh_int  <= cfg_int_i;
        r_sh_frac <= cfg_frac_i;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign cfg_pending_o = r_pending;
  assign div_int_o     = r_act_int;
  assign div_frac_o    = r_act_frac;
  assign rxclk_en_o    = r_rx;
  assign txclk_en_o    = r_tx;

endmodule
